// File: rtl/vc_tribus_pkg.sv
// Shared definitions for the tri-state bus arbiter: FSM state codes and the
// owner-index width helper.
package vc_tribus_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BURST = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_BURST = BURST,
        ST_TURN  = TURN
    } state_e;

    // Width of an owner/pointer index; never narrower than one bit.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from
// ptr_i with wrap-around.
module vc_rr_picker
    import vc_tribus_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [owner_w(NUM_REQ)-1:0]   ptr_i,
    output logic                          valid_o,
    output logic [owner_w(NUM_REQ)-1:0]   win_o,
    output logic [NUM_REQ-1:0]            win_oh_o
);

    localparam int IW = owner_w(NUM_REQ);

    always_comb begin
        int            j;
        logic [IW-1:0] idx;
        j        = 0;
        idx      = '0;
        valid_o  = 1'b0;
        win_o    = '0;
        win_oh_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(ptr_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            idx = IW'(j);
            if (!valid_o && req_i[idx]) begin
                valid_o = 1'b1;
                win_o   = idx;
            end
        end
        win_oh_o[win_o] = valid_o;
    end

endmodule

// File: rtl/vc_tribus_arbiter.sv
// Round-robin burst arbiter for a partitioned tri-state bus; every change of
// owner passes through one dead TURN cycle so drivers never overlap.
module vc_tribus_arbiter
    import vc_tribus_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_SZ  = 4
) (
    input  logic                        clk,
    input  logic                        reset_n_p,
    input  logic [NUM_REQ-1:0]          req_p,
    input  logic [NUM_REQ*LEN_SZ-1:0]   len_p,
    output logic [NUM_REQ-1:0]          oe_np,
    output logic [NUM_REQ-1:0]          start_np,
    output logic                        last_np,
    output logic                        busy_np,
    output logic [$clog2(NUM_REQ)-1:0]  owner_np
);

    localparam int IW = owner_w(NUM_REQ);

    state_e              state_q, state_d;
    logic [LEN_SZ-1:0]   cnt_q,   cnt_d;
    logic [IW-1:0]       ptr_q,   ptr_d;
    logic [IW-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]  oe_q,    oe_d;
    logic [NUM_REQ-1:0]  start_q, start_d;

    logic                pick_valid;
    logic [IW-1:0]       pick_win;
    logic [NUM_REQ-1:0]  pick_oh;

    vc_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req_i    (req_p),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .win_o    (pick_win),
        .win_oh_o (pick_oh)
    );

    always_ff @(posedge clk or negedge reset_n_p) begin
        if (!reset_n_p) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            owner_q <= '0;
            oe_q    <= '0;
            start_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            oe_q    <= oe_d;
            start_q <= start_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        oe_d    = oe_q;
        start_d = '0;
        case (state_q)
            // IDLE and TURN arbitrate identically; TURN only exists to hold oe low.
            ST_IDLE, ST_TURN: begin
                state_d = ST_IDLE;
                oe_d    = '0;
                if (pick_valid) begin
                    state_d = ST_BURST;
                    oe_d    = pick_oh;
                    start_d = pick_oh;
                    owner_d = pick_win;
                    cnt_d   = len_p[int'(pick_win)*LEN_SZ +: LEN_SZ];
                    ptr_d   = (int'(pick_win) == NUM_REQ - 1) ? '0 : pick_win + IW'(1);
                end
            end
            ST_BURST: begin
                if (!req_p[owner_q] || (cnt_q == '0)) begin
                    state_d = ST_TURN;
                    oe_d    = '0;
                end else begin
                    cnt_d = cnt_q - LEN_SZ'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                oe_d    = '0;
            end
        endcase
    end

    assign oe_np    = oe_q;
    assign start_np = start_q;
    assign last_np  = (state_q == ST_BURST) && (cnt_q == '0);
    assign busy_np  = |oe_q;
    assign owner_np = owner_q;

    oe_onehot_a: assert property (@(posedge clk) disable iff (!reset_n_p) $onehot0(oe_q));

endmodule

// File: tb/tb_vc_tribus_arbiter.sv
// Self-checking bench for vc_tribus_arbiter: directed scenarios plus random
// traffic compared against a burst-level behavioural model.
module tb_vc_tribus_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;

    logic            clk = 1'b0;
    logic            reset_n_p;
    logic [N-1:0]    req_p;
    logic [N*LW-1:0] len_p;
    logic [N-1:0]    oe_np;
    logic [N-1:0]    start_np;
    logic            last_np;
    logic            busy_np;
    logic [1:0]      owner_np;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    vc_tribus_arbiter #(
        .NUM_REQ (N),
        .LEN_SZ  (LW)
    ) dut (
        .clk       (clk),
        .reset_n_p (reset_n_p),
        .req_p     (req_p),
        .len_p     (len_p),
        .oe_np     (oe_np),
        .start_np  (start_np),
        .last_np   (last_np),
        .busy_np   (busy_np),
        .owner_np  (owner_np)
    );

    // Model: current owner (-1 = nobody), beats completed, burst length in beats.
    int           m_owner, m_done, m_blen, m_ptr, m_last;
    bit           m_arb;
    logic [N-1:0] m_arb_req;
    int           m_arb_win;

    function automatic void model_reset();
        m_owner = -1; m_done = 0; m_blen = 0; m_ptr = 0; m_last = 0;
        m_arb = 0; m_arb_req = '0; m_arb_win = -1;
    endfunction

    function automatic void model_edge();
        m_arb = 0;
        if (m_owner >= 0) begin
            m_done++;
            if (!req_p[m_owner] || m_done == m_blen) m_owner = -1;
        end else begin
            m_arb = 1; m_arb_req = req_p; m_arb_win = -1;
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (m_arb_win < 0 && req_p[c]) m_arb_win = c;
            end
            if (m_arb_win >= 0) begin
                m_owner = m_arb_win;
                m_last  = m_arb_win;
                m_done  = 0;
                m_blen  = int'(len_p[m_arb_win*LW +: LW]) + 1;
                m_ptr   = (m_arb_win + 1) % N;
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_oe();
        logic [N-1:0] e;
        e = '0;
        if (m_owner >= 0) e[m_owner] = 1'b1;
        return e;
    endfunction

    function automatic logic [N-1:0] exp_start();
        return (m_owner >= 0 && m_done == 0) ? exp_oe() : '0;
    endfunction

    function automatic logic exp_last();
        return (m_owner >= 0) && (m_done == m_blen - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n_p = 1'b0;
        req_p = '0;
        len_p = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n_p = 1'b1;
    endtask

    task automatic test_reset();
        checks++;
        if ({oe_np, start_np, last_np, busy_np, owner_np} !== 12'b0) begin
            errors++;
            $display("FAIL reset_state: got oe=%b start=%b last=%b busy=%b owner=%0d, expected all zero",
                     oe_np, start_np, last_np, busy_np, owner_np);
        end
        @(negedge clk);
        reset_n_p = 1'b1;
        tick();
        checks++;
        if (oe_np !== 4'b0 || busy_np !== 1'b0) begin
            errors++;
            $display("FAIL idle_no_req: got oe=%b busy=%b, expected 0000/0", oe_np, busy_np);
        end
    endtask

    task automatic test_single_burst();
        logic [N-1:0] eoe [5] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic [N-1:0] est [5] = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic         elst[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        req_p = 4'b0010;
        len_p = 16'h0020;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (oe_np !== eoe[c] || start_np !== est[c] || last_np !== elst[c] ||
                busy_np !== (eoe[c] != 0) || owner_np !== 2'd1) begin
                errors++;
                $display("FAIL single_burst cycle %0d: got oe=%b start=%b last=%b busy=%b owner=%0d, expected oe=%b start=%b last=%b owner=1",
                         c + 1, oe_np, start_np, last_np, busy_np, owner_np, eoe[c], est[c], elst[c]);
            end
            if (c == 3) req_p = '0;
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] want;
        do_reset();
        req_p = 4'b1111;
        len_p = 16'h0000;
        for (int b = 0; b < 5; b++) begin
            tick();
            want = 4'b0001 << (b % N);
            checks++;
            if (oe_np !== want || start_np !== want || last_np !== 1'b1 || owner_np !== 2'(b % N)) begin
                errors++;
                $display("FAIL round_robin burst %0d: got oe=%b start=%b last=%b owner=%0d, expected oe=%b start=%b last=1 owner=%0d",
                         b, oe_np, start_np, last_np, owner_np, want, want, b % N);
            end
            if (b == 4) req_p = '0;
            tick();
            checks++;
            if (oe_np !== 4'b0 || busy_np !== 1'b0) begin
                errors++;
                $display("FAIL round_robin dead %0d: got oe=%b busy=%b, expected 0000/0", b, oe_np, busy_np);
            end
        end
    endtask

    task automatic test_abort();
        logic [N-1:0] eoe[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000};
        int beats = 0;
        bit saw_last = 0;
        req_p = 4'b0001;
        len_p = 16'h0007;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (oe_np != 0) beats++;
            if (last_np) saw_last = 1;
            checks++;
            if (oe_np !== eoe[c]) begin
                errors++;
                $display("FAIL abort cycle %0d: got oe=%b, expected %b", c + 1, oe_np, eoe[c]);
            end
            if (c == 2) req_p = '0;
        end
        checks++;
        if (beats != 3 || saw_last) begin
            errors++;
            $display("FAIL abort_beats: got beats=%0d last_seen=%0d, expected beats=3 last_seen=0", beats, saw_last);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_p = 4'b0100;
        len_p = 16'h0700;
        repeat (3) tick();
        checks++;
        if (oe_np !== 4'b0100 || last_np !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset_burst: got oe=%b last=%b, expected 0100/0", oe_np, last_np);
        end
        #2;
        reset_n_p = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({oe_np, start_np, last_np, busy_np, owner_np} !== 12'b0) begin
            errors++;
            $display("FAIL async_reset: got oe=%b start=%b last=%b busy=%b owner=%0d, expected all zero",
                     oe_np, start_np, last_np, busy_np, owner_np);
        end
        req_p = 4'b1100;
        @(posedge clk);
        @(negedge clk);
        reset_n_p = 1'b1;
        tick();
        checks++;
        if (oe_np !== 4'b0100 || owner_np !== 2'd2 || start_np !== 4'b0100) begin
            errors++;
            $display("FAIL ptr_after_reset: got oe=%b owner=%0d start=%b, expected 0100/2/0100", oe_np, owner_np, start_np);
        end
        req_p = '0;
        repeat (3) tick();
    endtask

    task automatic test_max_len();
        req_p = 4'b1000;
        len_p = 16'hF000;
        for (int b = 1; b <= 16; b++) begin
            tick();
            checks++;
            if (oe_np !== 4'b1000 || last_np !== (b == 16) || start_np !== ((b == 1) ? 4'b1000 : 4'b0000)) begin
                errors++;
                $display("FAIL max_len beat %0d: got oe=%b last=%b start=%b, expected oe=1000 last=%0d", b, oe_np, last_np, start_np, b == 16);
            end
        end
        tick();
        checks++;
        if (oe_np !== 4'b0 || last_np !== 1'b0) begin
            errors++;
            $display("FAIL max_len_end: got oe=%b last=%b, expected 0000/0", oe_np, last_np);
        end
        req_p = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] eoe[6] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
        logic [N-1:0] est[6] = '{4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        req_p = 4'b0001;
        len_p = 16'h0001;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if (oe_np !== eoe[c] || start_np !== est[c]) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got oe=%b start=%b, expected oe=%b start=%b", c + 1, oe_np, start_np, eoe[c], est[c]);
            end
        end
        req_p = '0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [N-1:0] prev_oe;
        int           waits[N];
        logic [12:0]  got, exp;
        prev_oe = oe_np;
        for (int i = 0; i < N; i++) waits[i] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if ($urandom_range(7) == 0) req_p = N'($urandom);
            len_p = (N * LW)'($urandom);
            tick();
            got = {oe_np, start_np, last_np, busy_np, 1'b0, owner_np};
            exp = {exp_oe(), exp_start(), exp_last(), m_owner >= 0, 1'b0, 2'(m_last)};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random cycle %0d: got oe/start/last/busy/owner=%b, expected %b", cyc, got, exp);
            end
            checks++;
            if (!$onehot0(oe_np) || (prev_oe != 0 && oe_np != 0 && prev_oe != oe_np)) begin
                errors++;
                $display("FAIL random_overlap cycle %0d: got oe=%b after %b, expected onehot0 with a dead cycle between owners", cyc, oe_np, prev_oe);
            end
            prev_oe = oe_np;
            if (m_arb && m_arb_win >= 0) begin
                for (int i = 0; i < N; i++) begin
                    if (!m_arb_req[i] || m_arb_win == i) waits[i] = 0;
                    else waits[i]++;
                    checks++;
                    if (waits[i] > N - 1) begin
                        errors++;
                        $display("FAIL starvation req %0d: got %0d lost grants, expected at most %0d", i, waits[i], N - 1);
                    end
                end
            end
        end
        req_p = '0;
        repeat (20) tick();
    endtask

    initial begin
        reset_n_p = 1'b0;
        req_p = '0;
        len_p = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_abort();
        test_reset_mid_burst();
        test_max_len();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vc_tribus_arbiter.md
Name: vc_tribus_arbiter

Overview:
- Round-robin arbiter and burst sequencer for a shared tri-state bus built from partitioned tri-state buffers.
- Grants one of NUM_REQ requesters exclusive output-enable for a burst of programmable length.
- Inserts one dead (turnaround) cycle between owners so that no two drivers ever overlap.
- Its oe_np output drives the partitioned tri-state buffer's per-partition oe input directly.

Parameters:
- NUM_REQ, 4, number of requesters / bus partitions (>=2).
- LEN_SZ, 4, width of the per-request burst length field. A burst is len+1 beats, 1..2^LEN_SZ.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n_p  input  1  reset; asynchronous, active-low.
- req_p  input  NUM_REQ  request per requester; level, held for the whole burst.
- len_p  input  NUM_REQ*LEN_SZ  burst length minus one; requester i uses bits [i*LEN_SZ +: LEN_SZ].
- oe_np  output  NUM_REQ  registered one-hot (or zero) bus output-enable.
- start_np  output  NUM_REQ  one-cycle one-hot pulse on the first beat of a burst.
- last_np  output  1  high on the final beat of a burst.
- busy_np  output  1  high while any oe_np bit is set.
- owner_np  output  $clog2(NUM_REQ)  index of the current or most recent owner.

Behaviour:
- States: IDLE, BURST, TURN, encoded in 2 bits and registered.
- Reset, asynchronous and effective mid-burst:
  - state=IDLE; oe_np, start_np, last_np and busy_np all 0.
  - owner_np=0; priority pointer ptr=0; beat counter cnt=0.
  - oe_np drops within the reset assertion, not at the next edge.
- Arbitration runs only in IDLE and TURN. The winner is the first set req_p[i] scanning i = ptr, ptr+1, ... mod NUM_REQ.
- IDLE:
  - No request: stay in IDLE.
  - Request: at the next edge go to BURST with oe_np=onehot(win), start_np=onehot(win), owner_np=win, cnt=len_p[win], and ptr=(win+1) mod NUM_REQ.
  - Latency from req_p rising in IDLE to oe_np is 1 cycle.
- BURST:
  - Each cycle with req_p[owner] high and cnt!=0: cnt decrements and the state stays BURST.
  - last_np = (cnt==0) combinationally from registered state. It is therefore asserted on the final beat.
  - When cnt==0 and the burst beat completes, the next edge goes to TURN with oe_np=0.
  - Abort: if req_p[owner] is low in any BURST cycle, the next edge goes to TURN (oe_np=0). That cycle still counts as a beat. last_np is not forced.
  - start_np is high only in the first BURST cycle.
  - len_p is sampled only at grant. Changes during the burst are ignored.
- TURN:
  - Exactly one cycle with oe_np=0 and busy_np=0.
  - Arbitration runs with the already-advanced ptr. A winner goes directly to BURST at the next edge; no request goes to IDLE.
  - Back-to-back bursts are therefore separated by exactly 1 dead cycle.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 bursts.
- Single requester: repeated bursts of len+1 beats, each followed by one TURN cycle.
- Counter arithmetic: modulo 2^LEN_SZ. cnt never underflows, because the exit from BURST happens at cnt==0.
- Invariant, checked by an assertion: $onehot0(oe_np) every cycle.

Decomposition:
- Shared package vc_tribus_pkg holds:
  - state localparams IDLE=2'd0, BURST=2'd1, TURN=2'd2;
  - the owner index width function.
- One combinational sub-module, vc_rr_picker #(NUM_REQ): inputs req and ptr; outputs valid, win index, and win one-hot.
- The FSM, counter and pointer live in vc_tribus_arbiter.

Test Plan:
- Reset then req_p=4'b0010, len1=2 → oe_np=0010 on cycles 1-3; start_np on cycle 1; last_np on cycle 3; cycle 4 oe_np=0 (TURN); then IDLE.
- All req_p=1111 held, all len=0, ptr=0 → owners 0,1,2,3,0 each for 1 beat, with oe_np=0 in the cycle between each pair.
- req_p=0001 len0=7; req0 dropped on beat 3 → oe_np=0 on the next cycle, TURN, IDLE; total 3 beats; last_np never asserted.
- reset_n_p pulled low mid-burst (owner 2, cnt=5) → oe_np=0 immediately and asynchronously; after release, req_p=0100 yields owner 2 again (ptr reset to 0).
- len=4'hF single requester → 16 beats; last_np only on beat 16; no counter wrap.
- Random req_p/len_p stimulus for 10k cycles → $onehot0(oe_np) never violated; at least 1 dead cycle between different owners; starvation bound NUM_REQ-1 bursts.
